gcm_decrypt: RTL and testbench

GCM_DECRYPT -- requirements
Module: gcm_decrypt

---
 rtl/gcm_decrypt.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_gcm_decrypt.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : gcm_decrypt (with internal helper gcm_ghash)
// Purpose  : AES-GCM decryption sequencer. It drives an external AES core,
//            runs GHASH over AAD and ciphertext, releases plaintext blocks
//            and checks the received tag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports (gcm_decrypt):
//   clk_i, reset_ni             clock, synchronous active-low reset
//   start_i                     begin a decryption (sampled in IDLE only)
//   j0_i, subkey_h_i, tag_in_i  pre-counter block, hash subkey, received tag
//   aad_len_i, ct_len_i         lengths in bits (multiples of 128)
//   in_blk_i/in_valid_i/in_ready_o       AAD / ciphertext input stream
//   out_blk_o/out_valid_o/out_ready_i    plaintext output stream
//   aes_alg_in_blk_o/aes_alg_start_o     AES core request
//   aes_alg_out_blk_i/aes_alg_done_i     AES core response
//   busy_o, done_o, auth_ok_o   status
// ============================================================================

// ----------------------------------------------------------------------------
// gcm_ghash: computes y = (g ^ x) * h in GF(2^128) with the GCM bit order,
// processing 128/GFM_CYCLES multiplier bits per clock. done_o pulses once
// and y_o holds the result until the next start.
// ----------------------------------------------------------------------------
module gcm_ghash #(
  parameter int GFM_CYCLES = 8  // must divide 128
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         start_i,
  input  logic [127:0] g_i,
  input  logic [127:0] x_i,
  input  logic [127:0] h_i,
  output logic         done_o,
  output logic [127:0] y_o
);
  localparam int BPC = 128 / GFM_CYCLES;
  localparam int CW  = (GFM_CYCLES > 1) ? $clog2(GFM_CYCLES) : 1;
  localparam logic [127:0] GF_R = {8'he1, 120'h0};

  logic [127:0]  a_q, v_q, z_q, y_q;
  logic [127:0]  z_d, v_d;
  logic [CW-1:0] cnt_q;
  logic          run_q, done_q;

  // Bit 127 is the first (x0) coefficient; V shifts toward bit 0 and is
  // reduced by R whenever the x^127 coefficient falls off.
  always_comb begin
    z_d = z_q;
    v_d = v_q;
    for (int i = 0; i < BPC; i++) begin
      if (a_q[127-i]) z_d = z_d ^ v_d;
      v_d = v_d[0] ? ((v_d >> 1) ^ GF_R) : (v_d >> 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      a_q    <= '0;
      v_q    <= '0;
      z_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        a_q   <= g_i ^ x_i;
        v_q   <= h_i;
        z_q   <= '0;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        z_q   <= z_d;
        v_q   <= v_d;
        a_q   <= a_q << BPC;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(GFM_CYCLES - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
          y_q    <= z_d;
        end
      end
    end
  end

  assign done_o = done_q;
  assign y_o    = y_q;
endmodule

// ----------------------------------------------------------------------------
// gcm_decrypt top level
// ----------------------------------------------------------------------------
module gcm_decrypt #(
  parameter int GFM_CYCLES = 8
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         start_i,
  input  logic [127:0] j0_i,
  input  logic [127:0] subkey_h_i,
  input  logic [127:0] tag_in_i,
  input  logic [63:0]  aad_len_i,
  input  logic [63:0]  ct_len_i,
  input  logic [127:0] in_blk_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [127:0] out_blk_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] aes_alg_in_blk_o,
  output logic         aes_alg_start_o,
  input  logic [127:0] aes_alg_out_blk_i,
  input  logic         aes_alg_done_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         auth_ok_o
);
  typedef enum logic [3:0] {
    S_IDLE, S_EK0, S_AAD, S_CT_IN, S_CT_RUN, S_CT_OUT, S_LEN, S_TAG, S_DONE
  } state_e;

  state_e       state_q;
  logic [127:0] h_q, tag_q, len_q, ctr_q, g_q, ek0_q, c_q, ks_q;
  logic [127:0] out_blk_q, aes_in_q, gh_x_q;
  logic [56:0]  aad_left_q, ct_left_q;  // remaining 128-bit blocks
  logic         in_ready_q, out_valid_q, aes_start_q, gh_start_q;
  logic         busy_q, done_q, auth_ok_q;
  logic         wait_q;                 // GHASH in flight (AAD / LEN)
  logic         aes_got_q, gh_got_q;    // CT_RUN completion flags

  logic         w_gh_done;
  logic [127:0] w_gh_res;
  logic         w_aes_ok, w_gh_ok;
  logic [127:0] w_ks;

  function automatic logic [127:0] inc32(input logic [127:0] x);
    return {x[127:32], x[31:0] + 32'd1};
  endfunction

  gcm_ghash #(.GFM_CYCLES(GFM_CYCLES)) u_ghash (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .start_i  (gh_start_q),
    .g_i      (g_q),
    .x_i      (gh_x_q),
    .h_i      (h_q),
    .done_o   (w_gh_done),
    .y_o      (w_gh_res)
  );

  // The keystream and the hash may finish in either order or together.
  assign w_aes_ok = aes_got_q | aes_alg_done_i;
  assign w_gh_ok  = gh_got_q  | w_gh_done;
  assign w_ks     = aes_got_q ? ks_q : aes_alg_out_blk_i;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      h_q         <= '0;
      tag_q       <= '0;
      len_q       <= '0;
      ctr_q       <= '0;
      g_q         <= '0;
      ek0_q       <= '0;
      c_q         <= '0;
      ks_q        <= '0;
      out_blk_q   <= '0;
      aes_in_q    <= '0;
      gh_x_q      <= '0;
      aad_left_q  <= '0;
      ct_left_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      aes_start_q <= 1'b0;
      gh_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      auth_ok_q   <= 1'b0;
      wait_q      <= 1'b0;
      aes_got_q   <= 1'b0;
      gh_got_q    <= 1'b0;
    end else begin
      aes_start_q <= 1'b0;
      gh_start_q  <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            h_q         <= subkey_h_i;
            tag_q       <= tag_in_i;
            len_q       <= {aad_len_i, ct_len_i};
            aad_left_q  <= aad_len_i[63:7];
            ct_left_q   <= ct_len_i[63:7];
            ctr_q       <= inc32(j0_i);
            g_q         <= '0;
            aes_in_q    <= j0_i;
            aes_start_q <= 1'b1;
            busy_q      <= 1'b1;
            auth_ok_q   <= 1'b0;
            wait_q      <= 1'b0;
            state_q     <= S_EK0;
          end
        end
        S_EK0: begin
          if (aes_alg_done_i) begin
            ek0_q <= aes_alg_out_blk_i;
            if (aad_left_q != '0)     state_q <= S_AAD;
            else if (ct_left_q != '0) state_q <= S_CT_IN;
            else                      state_q <= S_LEN;
          end
        end
        S_AAD: begin
          if (wait_q) begin
            if (w_gh_done) begin
              g_q        <= w_gh_res;
              wait_q     <= 1'b0;
              aad_left_q <= aad_left_q - 57'd1;
              if (aad_left_q == 57'd1)
                state_q <= (ct_left_q != '0) ? S_CT_IN : S_LEN;
            end
          end else if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (in_valid_i) begin
            in_ready_q <= 1'b0;
            gh_x_q     <= in_blk_i;
            gh_start_q <= 1'b1;
            wait_q     <= 1'b1;
          end
        end
        S_CT_IN: begin
          if (!in_ready_q) begin
            in_ready_q <= 1'b1;
          end else if (in_valid_i) begin
            // Hash the ciphertext itself, launched alongside the keystream.
            in_ready_q  <= 1'b0;
            c_q         <= in_blk_i;
            gh_x_q      <= in_blk_i;
            gh_start_q  <= 1'b1;
            aes_in_q    <= ctr_q;
            aes_start_q <= 1'b1;
            aes_got_q   <= 1'b0;
            gh_got_q    <= 1'b0;
            state_q     <= S_CT_RUN;
          end
        end
        S_CT_RUN: begin
          if (aes_alg_done_i && !aes_got_q) begin
            ks_q      <= aes_alg_out_blk_i;
            aes_got_q <= 1'b1;
          end
          if (w_gh_done) gh_got_q <= 1'b1;
          if (w_aes_ok && w_gh_ok) begin
            out_blk_q   <= c_q ^ w_ks;
            g_q         <= w_gh_res;
            ctr_q       <= inc32(ctr_q);
            out_valid_q <= 1'b1;
            state_q     <= S_CT_OUT;
          end
        end
        S_CT_OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            ct_left_q   <= ct_left_q - 57'd1;
            state_q     <= (ct_left_q == 57'd1) ? S_LEN : S_CT_IN;
          end
        end
        S_LEN: begin
          if (!wait_q) begin
            gh_x_q     <= len_q;
            gh_start_q <= 1'b1;
            wait_q     <= 1'b1;
          end else if (w_gh_done) begin
            g_q     <= w_gh_res;
            wait_q  <= 1'b0;
            state_q <= S_TAG;
          end
        end
        S_TAG: begin
          auth_ok_q <= ((ek0_q ^ g_q) == tag_q);
          done_q    <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o       = in_ready_q;
  assign out_blk_o        = out_blk_q;
  assign out_valid_o      = out_valid_q;
  assign aes_alg_in_blk_o = aes_in_q;
  assign aes_alg_start_o  = aes_start_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign auth_ok_o        = auth_ok_q;
endmodule
`default_nettype wire

// File: tb/tb_gcm_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcm_decrypt
// Purpose  : Directed self-checking bench for gcm_decrypt. A behavioural AES
//            responder returns NIST GCM TC1/TC2 values for counters 1 and 2
//            and a masked counter otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcm_decrypt;
  localparam logic [127:0] H_K0   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] EK0_K0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C_TC2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] T_TC2  = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [127:0] T_BAD  = 128'hab6e47d42cec13bdf53a67b21257bdde;
  localparam logic [127:0] MASK   = 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  localparam logic [95:0]  UPW    = 96'h0123456789abcdef00112233;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] j0 = '0, subkey_h = '0, tag_in = '0, in_blk = '0;
  logic [63:0]  aad_len = '0, ct_len = '0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, aes_alg_start, busy, done, auth_ok;
  logic [127:0] out_blk, aes_alg_in_blk;
  logic [127:0] aes_alg_out_blk = '0;
  logic         aes_alg_done = 1'b0;

  int errors = 0;
  int checks = 0;
  int aes_n = 0, done_n = 0, inrdy_n = 0, ovalid_n = 0;
  int aes_lat = 2;
  logic [127:0] aes_reqs [0:63];

  always #5 clk = ~clk;

  gcm_decrypt #(.GFM_CYCLES(8)) dut (
    .clk_i            (clk),
    .reset_ni         (reset_n),
    .start_i          (start),
    .j0_i             (j0),
    .subkey_h_i       (subkey_h),
    .tag_in_i         (tag_in),
    .aad_len_i        (aad_len),
    .ct_len_i         (ct_len),
    .in_blk_i         (in_blk),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .out_blk_o        (out_blk),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .aes_alg_in_blk_o (aes_alg_in_blk),
    .aes_alg_start_o  (aes_alg_start),
    .aes_alg_out_blk_i(aes_alg_out_blk),
    .aes_alg_done_i   (aes_alg_done),
    .busy_o           (busy),
    .done_o           (done),
    .auth_ok_o        (auth_ok)
  );

  // AES with K = 0: E(0^96||1) and E(0^96||2) are the NIST TC1/TC2 values.
  function automatic logic [127:0] aes_model(input logic [127:0] b);
    if (b == 128'h1) return EK0_K0;
    if (b == 128'h2) return C_TC2;
    return b ^ MASK;
  endfunction

  // Event monitors on DUT outputs, sampled on the falling edge.
  always @(negedge clk) begin
    if (aes_alg_start === 1'b1) begin
      aes_reqs[aes_n % 64] = aes_alg_in_blk;
      aes_n++;
    end
    if (done === 1'b1)      done_n++;
    if (in_ready === 1'b1)  inrdy_n++;
    if (out_valid === 1'b1) ovalid_n++;
  end

  // AES responder: answers each request after aes_lat cycles.
  initial begin : aes_responder
    logic [127:0] req;
    forever begin
      @(negedge clk);
      if (aes_alg_start === 1'b1) begin
        req = aes_alg_in_blk;
        repeat (aes_lat) @(negedge clk);
        aes_alg_out_blk = aes_model(req);
        aes_alg_done = 1'b1;
        @(negedge clk);
        aes_alg_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic kick(input logic [127:0] j, input logic [127:0] h,
                      input logic [127:0] t, input logic [63:0] al,
                      input logic [63:0] cl);
    j0 = j; subkey_h = h; tag_in = t; aad_len = al; ct_len = cl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_blk(input string name, input logic [127:0] b);
    int k = 0;
    while (in_ready !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: in_ready got %b expected 1 (timeout)", name, in_ready);
    end else begin
      in_blk = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic recv_blk(input string name, output logic [127:0] b);
    int k = 0;
    b = 'x;
    while (out_valid !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: out_valid got %b expected 1 (timeout)", name, out_valid);
    end else begin
      b = out_blk; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic wait_done(input string name, output logic auth);
    int k = 0;
    auth = 1'bx;
    while (done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s: done got %b expected 1 (timeout)", name, done);
    end else begin
      auth = auth_ok;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, aes_alg_start, busy, done, auth_ok} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {in_ready, out_valid, aes_alg_start, busy, done, auth_ok});
    end
    checks++;
    if (out_blk !== 128'h0) begin
      errors++; $display("FAIL reset_out_blk: got %h expected 0", out_blk);
    end
    checks++;
    if (aes_alg_in_blk !== 128'h0) begin
      errors++; $display("FAIL reset_aes_in: got %h expected 0", aes_alg_in_blk);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tc1();
    int a0 = aes_n, r0 = inrdy_n;
    logic auth;
    kick(128'h1, H_K0, EK0_K0, 64'd0, 64'd0);
    wait_done("tc1_done", auth);
    checks++;
    if (auth !== 1'b1) begin errors++; $display("FAIL tc1_auth: got %b expected 1", auth); end
    checks++;
    if (aes_n - a0 != 1) begin errors++; $display("FAIL tc1_aes_count: got %0d expected 1", aes_n - a0); end
    checks++;
    if (aes_reqs[a0 % 64] !== 128'h1) begin
      errors++; $display("FAIL tc1_aes_req: got %h expected 1", aes_reqs[a0 % 64]);
    end
    checks++;
    if (inrdy_n != r0) begin errors++; $display("FAIL tc1_no_input: got %0d in_ready cycles expected 0", inrdy_n - r0); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL tc1_idle_busy: got %b expected 0", busy); end
    checks++;
    if (auth_ok !== 1'b1) begin errors++; $display("FAIL tc1_auth_held: got %b expected 1", auth_ok); end
  endtask

  task automatic test_tc2(input string name, input logic [127:0] tag, input logic exp_auth);
    int a0 = aes_n;
    logic [127:0] p;
    logic auth;
    kick(128'h1, H_K0, tag, 64'd0, 64'd128);
    send_blk(name, C_TC2);
    recv_blk(name, p);
    checks++;
    if (p !== 128'h0) begin errors++; $display("FAIL %s_plain: got %h expected 0", name, p); end
    wait_done(name, auth);
    checks++;
    if (auth !== exp_auth) begin errors++; $display("FAIL %s_auth: got %b expected %b", name, auth, exp_auth); end
    checks++;
    if (aes_n - a0 != 2) begin errors++; $display("FAIL %s_aes_count: got %0d expected 2", name, aes_n - a0); end
    checks++;
    if (aes_reqs[(a0 + 1) % 64] !== 128'h2) begin
      errors++; $display("FAIL %s_ctr: got %h expected 2", name, aes_reqs[(a0 + 1) % 64]);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    int a0 = aes_n;
    logic [127:0] p0, p1;
    logic [127:0] c0 = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] c1 = 128'hfedcba98765432100123456789abcdef;
    logic [127:0] ca = {UPW, 32'hffffffff};
    logic [127:0] cb = {UPW, 32'h00000000};
    logic auth;
    kick({UPW, 32'hfffffffe}, H_K0, 128'h0, 64'd0, 64'd256);
    send_blk("wrap_c0", c0);
    recv_blk("wrap_p0", p0);
    send_blk("wrap_c1", c1);
    recv_blk("wrap_p1", p1);
    wait_done("wrap_done", auth);
    checks++;
    if (aes_reqs[(a0 + 1) % 64] !== ca) begin
      errors++; $display("FAIL wrap_ctr1: got %h expected %h", aes_reqs[(a0 + 1) % 64], ca);
    end
    checks++;
    if (aes_reqs[(a0 + 2) % 64] !== cb) begin
      errors++; $display("FAIL wrap_ctr2: got %h expected %h", aes_reqs[(a0 + 2) % 64], cb);
    end
    checks++;
    if (p0 !== (c0 ^ ca ^ MASK)) begin
      errors++; $display("FAIL wrap_p0: got %h expected %h", p0, c0 ^ ca ^ MASK);
    end
    checks++;
    if (p1 !== (c1 ^ cb ^ MASK)) begin
      errors++; $display("FAIL wrap_p1: got %h expected %h", p1, c1 ^ cb ^ MASK);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int k = 0;
    int a_snap, r_snap;
    logic [127:0] p;
    logic auth;
    kick(128'h1, H_K0, T_TC2, 64'd0, 64'd128);
    send_blk("bp_c", C_TC2);
    while (out_valid !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_valid: got %b expected 1 (timeout)", out_valid);
    end
    a_snap = aes_n;
    r_snap = inrdy_n;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_blk !== 128'h0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b blk=%h in_ready=%b expected 1/0/0",
                 i, out_valid, out_blk, in_ready);
      end
    end
    checks++;
    if (aes_n != a_snap || inrdy_n != r_snap) begin
      errors++;
      $display("FAIL bp_quiet: got %0d aes starts %0d in_ready cycles expected 0/0",
               aes_n - a_snap, inrdy_n - r_snap);
    end
    recv_blk("bp_p", p);
    checks++;
    if (p !== 128'h0) begin errors++; $display("FAIL bp_plain: got %h expected 0", p); end
    wait_done("bp_done", auth);
    checks++;
    if (auth !== 1'b1) begin errors++; $display("FAIL bp_auth: got %b expected 1", auth); end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int k = 0;
    int d0, o0;
    aes_lat = 8;  // AES answer lands after the reset pulse
    kick(128'h1, H_K0, T_TC2, 64'd0, 64'd128);
    send_blk("rst_c", C_TC2);
    while (aes_alg_start !== 1'b1 && k < 30) begin @(negedge clk); k++; end
    checks++;
    if (aes_alg_start !== 1'b1) begin
      errors++; $display("FAIL rst_ct_run: aes start got %b expected 1 (timeout)", aes_alg_start);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    d0 = done_n;
    o0 = ovalid_n;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++;
    if (done_n != d0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", done_n - d0); end
    checks++;
    if (ovalid_n != o0) begin errors++; $display("FAIL rst_no_valid: got %0d expected 0", ovalid_n - o0); end
    aes_lat = 2;
  endtask

  initial begin : main
    test_reset();
    test_tc1();
    test_tc2("tc2", T_TC2, 1'b1);
    test_tc2("tc2_badtag", T_BAD, 1'b0);
    test_wrap();
    test_backpressure();
    test_reset_midrun();
    test_tc2("tc2_after_rst", T_TC2, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
